aes_inv_key_schedule: RTL and testbench

- Sequential AES-128 key schedule for the decryption datapath. Supplies round keys in reverse order: round 10 first, round 0 last.
- Loads a cipher key and derives the round-10 key by forward expansion, one round per clock. Then steps backward one round per `next` request, inverting the FIPS-197 recurrence.
- Replaces the 1408-bit combinational key table in the decrypt path with a single 128-bit working register and four shared `sbox` instances.

---
 rtl/aes_inv_key_schedule.sv | 162 ++++++++++++++++
 tb/tb_aes_inv_key_schedule.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_schedule.sv
// Sequential AES-128 key schedule that supplies round keys 10 down to 0 for decryption.
// It uses one 128-bit working register and four byte S-boxes, shared by forward and inverse steps.
module aes_inv_key_schedule #(
   parameter bit LOAD_LAST = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         next,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         key_valid,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

   state_e       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   idx_q, idx_d;
   logic         valid_q, valid_d;
   logic         busy_q, busy_d;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (x^254, with 0 mapped to 0) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] t;
      logic [7:0] b;
      t = gf_mul(x, x);              // x^2
      t = gf_mul(t, x);              // x^3
      t = gf_mul(gf_mul(t, t), x);   // x^7
      t = gf_mul(gf_mul(t, t), x);   // x^15
      t = gf_mul(gf_mul(t, t), x);   // x^31
      t = gf_mul(gf_mul(t, t), x);   // x^63
      t = gf_mul(gf_mul(t, t), x);   // x^127
      b = gf_mul(t, t);              // x^254
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
             ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      case (r)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   logic [31:0] a0, a1, a2, a3;
   logic [31:0] sel_word, sbox_in, sub_word;
   logic [31:0] fwd_t, n0, n1, n2, n3;
   logic [31:0] p0, p1, p2, p3;

   assign a0 = key_q[127:96];
   assign a1 = key_q[95:64];
   assign a2 = key_q[63:32];
   assign a3 = key_q[31:0];

   // The S-box input is selected by direction: EXPAND uses a3, READY uses a3^a2.
   assign sel_word = (state_q == StExpand) ? a3 : (a3 ^ a2);
   assign sbox_in  = {sel_word[23:0], sel_word[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      assign sub_word[8*g +: 8] = sbox(sbox_in[8*g +: 8]);
   end

   assign fwd_t = sub_word ^ {rcon(idx_q + 4'd1), 24'h0};
   assign n0    = a0 ^ fwd_t;
   assign n1    = a1 ^ n0;
   assign n2    = a2 ^ n1;
   assign n3    = a3 ^ n2;

   assign p3 = a3 ^ a2;
   assign p2 = a2 ^ a1;
   assign p1 = a1 ^ a0;
   assign p0 = a0 ^ sub_word ^ {rcon(idx_q), 24'h0};

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      unique case (state_q)
         StIdle, StReady: begin
            if (start) begin
               key_d = key_in;
               if (LOAD_LAST) begin
                  idx_d   = 4'd10;
                  state_d = StReady;
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  idx_d   = 4'd0;
                  state_d = StExpand;
                  valid_d = 1'b0;
                  busy_d  = 1'b1;
               end
            end else if (state_q == StReady && next && idx_q != 4'd0) begin
               key_d = {p0, p1, p2, p3};
               idx_d = idx_q - 4'd1;
            end
         end
         StExpand: begin
            key_d = {n0, n1, n2, n3};
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd9) begin
               state_d = StReady;
               busy_d  = 1'b0;
               valid_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         key_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign round_key = key_q;
   assign round_idx = idx_q;
   assign key_valid = valid_q;
   assign busy      = busy_q;
   assign done      = valid_q && (idx_q == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for the reverse-order AES-128 key schedule, covering both load modes.
// It uses the FIPS-197 key 2b7e1516... and the 000102...0f key.
module tb_aes_inv_key_schedule;

   localparam logic [127:0] KEY0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] KEY9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] KEY10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEYB0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEYB10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_a, next_a, start_b, next_b;
   logic [127:0] key_in_a, key_in_b;
   logic [127:0] round_key_a, round_key_b;
   logic [3:0]   round_idx_a, round_idx_b;
   logic         key_valid_a, key_valid_b, busy_a, busy_b, done_a, done_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_inv_key_schedule #(.LOAD_LAST(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .key_in(key_in_a), .next(next_a),
      .round_key(round_key_a), .round_idx(round_idx_a), .key_valid(key_valid_a),
      .busy(busy_a), .done(done_a)
   );

   aes_inv_key_schedule #(.LOAD_LAST(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .key_in(key_in_b), .next(next_b),
      .round_key(round_key_b), .round_idx(round_idx_b), .key_valid(key_valid_b),
      .busy(busy_b), .done(done_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_a = 0; next_a = 0; start_b = 0; next_b = 0;
      key_in_a = '0; key_in_b = '0;
      tick(); tick();
      rst_n = 1'b1;
      checks++;
      if ({round_key_a, round_idx_a, key_valid_a, busy_a, done_a} !== '0) begin
         errors++;
         $display("FAIL reset_a got key=%h idx=%0d v=%b b=%b d=%b want all zero",
                  round_key_a, round_idx_a, key_valid_a, busy_a, done_a);
      end
      checks++;
      if ({round_key_b, round_idx_b, key_valid_b, busy_b, done_b} !== '0) begin
         errors++;
         $display("FAIL reset_b got key=%h idx=%0d v=%b b=%b d=%b want all zero",
                  round_key_b, round_idx_b, key_valid_b, busy_b, done_b);
      end
   endtask

   task automatic expand_a(input logic [127:0] key);
      int cnt;
      key_in_a = key; start_a = 1;
      tick();
      start_a = 0;
      cnt = 0;
      while (busy_a && cnt < 20) begin
         cnt++;
         tick();
      end
      checks++;
      if (cnt != 10) begin
         errors++;
         $display("FAIL busy_cycles got %0d want 10", cnt);
      end
   endtask

   task automatic test_expand();
      expand_a(KEY0);
      checks++;
      if (key_valid_a !== 1'b1 || round_idx_a !== 4'd10 || round_key_a !== KEY10) begin
         errors++;
         $display("FAIL expand_result got v=%b idx=%0d key=%h want v=1 idx=10 key=%h",
                  key_valid_a, round_idx_a, round_key_a, KEY10);
      end
   endtask

   task automatic test_inverse_walk();
      next_a = 1;
      tick();
      next_a = 0;
      checks++;
      if (round_idx_a !== 4'd9 || round_key_a !== KEY9) begin
         errors++;
         $display("FAIL step_9 got idx=%0d key=%h want idx=9 key=%h",
                  round_idx_a, round_key_a, KEY9);
      end
      next_a = 1;
      for (int i = 8; i >= 0; i--) begin
         tick();
         checks++;
         if (round_idx_a !== 4'(i) || key_valid_a !== 1'b1) begin
            errors++;
            $display("FAIL step_idx got idx=%0d v=%b want idx=%0d v=1",
                     round_idx_a, key_valid_a, i);
         end
         if (i == 1) begin
            checks++;
            if (round_key_a !== KEY1) begin
               errors++;
               $display("FAIL round1_key got %h want %h", round_key_a, KEY1);
            end
         end
      end
      checks++;
      if (round_key_a !== KEY0 || done_a !== 1'b1) begin
         errors++;
         $display("FAIL round0 got key=%h done=%b want key=%h done=1", round_key_a, done_a, KEY0);
      end
      tick();
      next_a = 0;
      checks++;
      if (round_key_a !== KEY0 || round_idx_a !== 4'd0 || done_a !== 1'b1 ||
          key_valid_a !== 1'b1 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL next_at_zero got key=%h idx=%0d done=%b want key=%h idx=0 done=1",
                  round_key_a, round_idx_a, done_a, KEY0);
      end
   endtask

   task automatic test_load_last();
      key_in_b = KEY10; start_b = 1;
      tick();
      start_b = 0;
      checks++;
      if (key_valid_b !== 1'b1 || round_idx_b !== 4'd10 || round_key_b !== KEY10 ||
          busy_b !== 1'b0) begin
         errors++;
         $display("FAIL load_last got v=%b idx=%0d key=%h busy=%b want v=1 idx=10 busy=0",
                  key_valid_b, round_idx_b, round_key_b, busy_b);
      end
      for (int i = 0; i < 10; i++) begin
         next_b = 1; tick();
         next_b = 0; tick();
      end
      checks++;
      if (round_key_b !== KEY0 || round_idx_b !== 4'd0 || done_b !== 1'b1) begin
         errors++;
         $display("FAIL load_last_walk got key=%h idx=%0d done=%b want key=%h idx=0 done=1",
                  round_key_b, round_idx_b, done_b, KEY0);
      end
   endtask

   task automatic test_reset_mid_expand();
      key_in_a = KEY0; start_a = 1;
      tick();
      start_a = 0;
      repeat (4) tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      checks++;
      if ({round_key_a, round_idx_a, key_valid_a, busy_a, done_a} !== '0) begin
         errors++;
         $display("FAIL reset_mid_expand got key=%h idx=%0d v=%b b=%b want all zero",
                  round_key_a, round_idx_a, key_valid_a, busy_a);
      end
      next_a = 1;
      repeat (3) tick();
      next_a = 0;
      checks++;
      if ({round_key_a, round_idx_a, key_valid_a, busy_a, done_a} !== '0) begin
         errors++;
         $display("FAIL next_in_idle got key=%h idx=%0d v=%b b=%b want all zero",
                  round_key_a, round_idx_a, key_valid_a, busy_a);
      end
   endtask

   task automatic test_start_with_next();
      expand_a(KEY0);
      repeat (6) begin
         next_a = 1; tick();
      end
      next_a = 0;
      checks++;
      if (round_idx_a !== 4'd4) begin
         errors++;
         $display("FAIL walk_to_4 got idx=%0d want 4", round_idx_a);
      end
      key_in_a = KEYB0; start_a = 1; next_a = 1;
      tick();
      start_a = 0; next_a = 0;
      checks++;
      if (busy_a !== 1'b1 || key_valid_a !== 1'b0 || round_idx_a !== 4'd0 ||
          round_key_a !== KEYB0) begin
         errors++;
         $display("FAIL start_wins got busy=%b v=%b idx=%0d key=%h want busy=1 v=0 idx=0 key=%h",
                  busy_a, key_valid_a, round_idx_a, round_key_a, KEYB0);
      end
      repeat (10) tick();
      checks++;
      if (key_valid_a !== 1'b1 || round_idx_a !== 4'd10 || round_key_a !== KEYB10) begin
         errors++;
         $display("FAIL second_key got v=%b idx=%0d key=%h want v=1 idx=10 key=%h",
                  key_valid_a, round_idx_a, round_key_a, KEYB10);
      end
   endtask

   initial begin
      test_reset();
      test_expand();
      test_inverse_walk();
      test_load_last();
      test_reset_mid_expand();
      test_start_with_next();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
